tx_status_rec_ctrl: RTL
=======================

# tx_status_rec_ctrl

Record-level controller for the tx status FIFO bank in `tx_intf`. The bank is eight parallel 32-bit FIFOs, depth 64, that together hold one tx-completion record. This block gates the shared write strobe so the bank never overflows, tracks record occupancy, and turns the per-word AXI register reads into one atomic pop of all eight FIFOs. It also produces a coalesced interrupt to the driver.

## Interface
Parameters:
- `DEPTH`, 64: records the FIFO bank can hold.
- `FIRST_ADDR`, 5'h16: register address that opens a record read.
- `LAST_ADDR`, 5'h1e: register address that commits the record (pop).
- `HOLD_TO_W`, 12: width of the hold-timeout counter.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rec_push`  in  1  one-cycle pulse: a completed record is presented on the bank's din.
- `slv_reg_rden`  in  1  AXI-lite read strobe.
- `axi_araddr_core`  in  5  AXI-lite word address.
- `irq_en`  in  1  interrupt enable.
- `irq_thresh`  in  7  occupancy threshold, 1..DEPTH. A value of 0 is treated as 1.
- `irq_timeout`  in  16  maximum record age in cycles before irq. 0 disables the age trigger.
- `hold_timeout`  in  HOLD_TO_W  maximum cycles spent in HOLD.
- `fifo_wr_en`  out  1  shared write enable to all eight FIFOs.
- `fifo_pop`  out  1  shared rd_en to all eight FIFOs.
- `rec_cnt`  out  7  records currently stored.
- `rec_empty`  out  1  high when `rec_cnt` == 0.
- `busy`  out  1  high while in HOLD.
- `irq`  out  1  level interrupt.
- `drop_cnt`  out  16  records dropped because the bank was full. Saturates.
- `abort_cnt`  out  16  HOLD timeouts. Saturates.

## Operation
- Outputs are registered.
- Reset values: `fifo_wr_en`=0, `fifo_pop`=0, `rec_cnt`=0, `rec_empty`=1, `busy`=0, `irq`=0, `drop_cnt`=0, `abort_cnt`=0, state=IDLE, age and hold timers=0.
- Push:
  - `rec_push` with `rec_cnt` < DEPTH is accepted. The block asserts `fifo_wr_en` for one cycle.
  - `rec_push` with `rec_cnt` == DEPTH is dropped. `fifo_wr_en` stays 0 and `drop_cnt` increments, saturating at 16'hFFFF.
  - A pop in the same cycle does not free space for that push; the full check uses the current `rec_cnt`.
- State machine, states IDLE, HOLD, POP:
  - IDLE -> HOLD: read strobe at FIRST_ADDR with `rec_cnt` > 0. The hold timer clears.
  - IDLE, read of FIRST_ADDR with `rec_cnt` == 0: stay in IDLE. The bank returns its empty words (FFFFFFFF, then 0s).
  - HOLD -> POP: read strobe at LAST_ADDR.
  - HOLD -> IDLE without a pop: the hold timer reaches `hold_timeout`. `abort_cnt` increments, saturating at 16'hFFFF.
  - HOLD, re-read of FIRST_ADDR: stay in HOLD and restart the hold timer.
  - POP -> IDLE: unconditional, after one cycle.
  - A read of LAST_ADDR in IDLE is ignored and does not pop.
- Occupancy: `rec_cnt` increments on an accepted push and decrements on `fifo_pop`. A simultaneous accepted push and pop leaves it unchanged. It never wraps below 0 or above DEPTH.
- Interrupt:
  - The age timer counts while `rec_cnt` > 0.
  - It clears on `fifo_pop` and while `rec_cnt` == 0.
  - It saturates at 16'hFFFF.
  - `irq` = `irq_en` & ((`rec_cnt` >= max(`irq_thresh`,1)) | (`irq_timeout` != 0 & age >= `irq_timeout`)), registered.

## Timing
- `rec_push` in cycle N:
  - `fifo_wr_en` is high in N+1.
  - `rec_cnt` reflects the new record in N+1.
  - `irq` can rise in N+2.
- Read strobe at LAST_ADDR in HOLD, cycle N:
  - State is POP in N+1, with `fifo_pop` high for exactly N+1.
  - `rec_cnt` decrements in N+2, and state returns to IDLE in N+2.
  - The next record is visible at the FIFO outputs (FWFT) by N+3.
- `busy` is high exactly while the state is HOLD.
- The hold timeout fires on the cycle the timer equals `hold_timeout`. `busy` falls the next cycle.
- `rst` asserted mid-HOLD or mid-POP: the block returns to the reset values immediately, with no pop issued. The bank is reset by the same `rst`, so counts remain consistent.

## Configuration
- `TX_STATUS_STATS_EN` defined: `drop_cnt` and `abort_cnt` are implemented as described.
- `TX_STATUS_STATS_EN` undefined:
  - Both outputs are tied to 16'd0 and the counters are not synthesized.
  - Drop and abort behaviour is otherwise unchanged: drops still gate `fifo_wr_en`, and timeouts still return to IDLE.

## Test plan
- Reset, then 3 `rec_push` pulses -> `fifo_wr_en` high 3 cycles, each one cycle after its push; `rec_cnt`=3; `rec_empty`=0; `fifo_pop`=0.
- `rec_cnt`=2, read FIRST_ADDR then LAST_ADDR -> `busy` high between the two reads; single `fifo_pop` pulse one cycle after the LAST_ADDR read; `rec_cnt`=1.
- 66 pushes with no reads -> `rec_cnt`=64; `fifo_wr_en` asserted 64 times; `drop_cnt`=2 (0 with `TX_STATUS_STATS_EN` undefined).
- `rec_cnt`=64, accepted pop and `rec_push` in the same cycle -> push dropped (`drop_cnt` +1); `rec_cnt`=63 after the pop.
- `hold_timeout`=100, read FIRST_ADDR, then no LAST_ADDR read -> return to IDLE after 100 cycles; `abort_cnt`=1; no `fifo_pop`; `rec_cnt` unchanged.
- `irq_en`=1, `irq_thresh`=4, `irq_timeout`=500, one push -> `irq` rises when the age reaches 500; a pop clears it.
- Same settings, 4 pushes -> `irq` high 2 cycles after the 4th push.

Source files
------------

// File: rtl/tx_status_rec_ctrl.sv
// tx_status_rec_ctrl: record-level write gating, occupancy, atomic pop and irq for the tx status FIFO bank (stats counters under TX_STATUS_STATS_EN)
module tx_status_rec_ctrl #(
  parameter int DEPTH = 64,
  parameter logic [4:0] FIRST_ADDR = 5'h16,
  parameter logic [4:0] LAST_ADDR = 5'h1e,
  parameter int HOLD_TO_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rec_push,
  input  logic                 slv_reg_rden,
  input  logic [4:0]           axi_araddr_core,
  input  logic                 irq_en,
  input  logic [6:0]           irq_thresh,
  input  logic [15:0]          irq_timeout,
  input  logic [HOLD_TO_W-1:0] hold_timeout,
  output logic                 fifo_wr_en,
  output logic                 fifo_pop,
  output logic [6:0]           rec_cnt,
  output logic                 rec_empty,
  output logic                 busy,
  output logic                 irq,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          abort_cnt
);
  typedef enum logic [1:0] {IDLE, HOLD, POP} state_t;
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);
  state_t state, state_nx;
  logic [HOLD_TO_W-1:0] hold_tmr, hold_tmr_nx;
  logic [15:0] age;
  logic [6:0] rec_cnt_nx, thr;
  logic rd_first, rd_last, accept;
  assign rd_first = slv_reg_rden && axi_araddr_core == FIRST_ADDR;
  assign rd_last = slv_reg_rden && axi_araddr_core == LAST_ADDR;
  assign accept = rec_push && rec_cnt < DEPTH_C;
  assign thr = irq_thresh == 7'd0 ? 7'd1 : irq_thresh;
  always_comb begin
    state_nx = state;
    hold_tmr_nx = hold_tmr;
    case (state)
      IDLE: begin
        if (rd_first && rec_cnt != 7'd0) begin
          state_nx = HOLD;
          hold_tmr_nx = '0;
        end
      end
      HOLD: begin
        if (rd_last) state_nx = POP;
        else if (rd_first) hold_tmr_nx = '0;
        else if (hold_tmr == hold_timeout) state_nx = IDLE;
        else hold_tmr_nx = hold_tmr + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  // a pop in the same cycle never frees space for the concurrent push
  always_comb begin
    rec_cnt_nx = rec_cnt;
    if (accept && !fifo_pop) rec_cnt_nx = rec_cnt + 7'd1;
    else if (!accept && fifo_pop && rec_cnt != 7'd0) rec_cnt_nx = rec_cnt - 7'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold_tmr <= '0;
      fifo_wr_en <= 1'b0;
      fifo_pop <= 1'b0;
      rec_cnt <= '0;
      rec_empty <= 1'b1;
      busy <= 1'b0;
      age <= '0;
      irq <= 1'b0;
    end else begin
      state <= state_nx;
      hold_tmr <= hold_tmr_nx;
      fifo_wr_en <= accept;
      fifo_pop <= state_nx == POP;
      busy <= state_nx == HOLD;
      rec_cnt <= rec_cnt_nx;
      rec_empty <= rec_cnt_nx == 7'd0;
      age <= (fifo_pop || rec_cnt == 7'd0) ? '0 : age + {15'd0, age != 16'hFFFF};
      irq <= irq_en && (rec_cnt >= thr || (irq_timeout != 16'd0 && age >= irq_timeout));
    end
  end
`ifdef TX_STATUS_STATS_EN
  logic drop, abort;
  assign drop = rec_push && !accept;
  assign abort = state == HOLD && !rd_last && !rd_first && hold_tmr == hold_timeout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      drop_cnt <= drop_cnt + 16'(drop && drop_cnt != 16'hFFFF);
      abort_cnt <= abort_cnt + 16'(abort && abort_cnt != 16'hFFFF);
    end
  end
`else
  assign drop_cnt = '0;
  assign abort_cnt = '0;
`endif
endmodule
